// File: rtl/sad_result_collector_if.sv
// sad_result_collector_if: per-core result inputs, ack/start control and best-result outputs
interface sad_result_collector_if #(
  parameter int NUM_CORES  = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  logic                             start;
  logic                             ack;
  logic [NUM_CORES-1:0]             core_done;
  logic [NUM_CORES*DATA_WIDTH-1:0]  min_in;
  logic [NUM_CORES*DATA_WIDTH-1:0]  v0_in;
  logic [NUM_CORES*DATA_WIDTH-1:0]  v1_in;
  logic [DATA_WIDTH-1:0]            min_out;
  logic [DATA_WIDTH-1:0]            v0_out;
  logic [DATA_WIDTH-1:0]            v1_out;
  logic [CW-1:0]                    best_core;
  logic [NUM_CORES-1:0]             captured_mask;
  logic                             busy;
  logic                             result_valid;
  logic                             timed_out;
  modport master (
    output start, ack, core_done, min_in, v0_in, v1_in,
    input  min_out, v0_out, v1_out, best_core, captured_mask, busy, result_valid, timed_out
  );
  modport slave (
    input  start, ack, core_done, min_in, v0_in, v1_in,
    output min_out, v0_out, v1_out, best_core, captured_mask, busy, result_valid, timed_out
  );
endinterface

// File: rtl/sad_result_collector.sv
// sad_result_collector: gathers per-core SAD minima one per cycle and keeps the best, with timeout
module sad_result_collector #(
  parameter int NUM_CORES  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 65535
) (
  input logic clk,
  input logic reset,
  sad_result_collector_if.slave bus
);
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t state;
  logic [TW-1:0] cnt;
  logic [NUM_CORES-1:0] pending, pick, next_mask;
  logic [CW-1:0] sel;
  logic [DATA_WIDTH-1:0] cand;
  logic better;
  always_comb begin
    pending = bus.core_done & ~bus.captured_mask;
    pick = pending & (~pending + 1'b1);
    next_mask = bus.captured_mask | pick;
    sel = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) sel = pending[i] ? CW'(i) : sel;
    cand = bus.min_in[sel*DATA_WIDTH +: DATA_WIDTH];
    better = |pending && (cand < bus.min_out || (cand == bus.min_out && sel < bus.best_core));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.min_out <= '1;
      bus.v0_out <= '0;
      bus.v1_out <= '0;
      bus.best_core <= '0;
      bus.captured_mask <= '0;
      bus.busy <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.timed_out <= 1'b0;
    end else if (state == COLLECT) begin
      cnt <= cnt + 1'b1;
      bus.captured_mask <= next_mask;
      if (better) begin
        bus.min_out <= cand;
        bus.v0_out <= bus.v0_in[sel*DATA_WIDTH +: DATA_WIDTH];
        bus.v1_out <= bus.v1_in[sel*DATA_WIDTH +: DATA_WIDTH];
        bus.best_core <= sel;
      end
      // completion wins over a simultaneous timeout
      if (&next_mask || cnt == TW'(TIMEOUT - 1)) begin
        state <= DONE;
        bus.busy <= 1'b0;
        bus.result_valid <= 1'b1;
        bus.timed_out <= ~&next_mask;
      end
    end else if (bus.start) begin
      state <= COLLECT;
      cnt <= '0;
      bus.min_out <= '1;
      bus.v0_out <= '0;
      bus.v1_out <= '0;
      bus.best_core <= '0;
      bus.captured_mask <= '0;
      bus.busy <= 1'b1;
      bus.result_valid <= 1'b0;
      bus.timed_out <= 1'b0;
    end else if (state == DONE && bus.ack) begin
      state <= IDLE;
      bus.result_valid <= 1'b0;
      bus.timed_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sad_result_collector.sv
// tb_sad_result_collector: directed and random frames checked against a schedule-level model
module tb_sad_result_collector;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int r[8];
  logic [31:0] mn[8], a[8], b[8];
  logic [31:0] em, ev0, ev1;
  logic [2:0] eb;
  logic [7:0] emask;
  int elat;
  logic eto;
  always #5 clk = ~clk;
  sad_result_collector_if #(.NUM_CORES(8), .DATA_WIDTH(32)) bus ();
  sad_result_collector #(.NUM_CORES(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model();
    logic [7:0] pend;
    int j;
    emask = '0; elat = 16; eto = 1'b1;
    for (int k = 0; k < 16; k++) begin
      pend = '0;
      j = 0;
      for (int i = 0; i < 8; i++) if (r[i] <= k && !emask[i]) pend[i] = 1'b1;
      for (int i = 7; i >= 0; i--) if (pend[i]) j = i;
      if (pend != 0) emask[j] = 1'b1;
      if (&emask) begin elat = k + 1; eto = 1'b0; break; end
    end
    em = '1; eb = '0; ev0 = '0; ev1 = '0;
    for (int i = 0; i < 8; i++)
      if (emask[i] && mn[i] < em) begin em = mn[i]; eb = 3'(i); ev0 = a[i]; ev1 = b[i]; end
  endtask
  task automatic run_frame(input string tag, input bit noisy);
    logic [7:0] cd;
    int lat;
    model();
    for (int i = 0; i < 8; i++) begin
      bus.min_in[i*32 +: 32] = mn[i];
      bus.v0_in[i*32 +: 32] = a[i];
      bus.v1_in[i*32 +: 32] = b[i];
    end
    bus.start = 1'b1;
    bus.ack = 1'($urandom_range(0, 1));
    bus.core_done = 8'($urandom);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.ack = 1'b0;
    chk({tag, "_entry_busy"}, 32'(bus.busy), 1);
    chk({tag, "_entry_valid"}, 32'(bus.result_valid), 0);
    chk({tag, "_entry_min"}, bus.min_out, 32'hffffffff);
    chk({tag, "_entry_mask"}, 32'(bus.captured_mask), 0);
    lat = 0;
    while (!bus.result_valid && lat < 20) begin
      for (int i = 0; i < 8; i++) cd[i] = r[i] <= lat;
      bus.core_done = cd;
      bus.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.ack = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    bus.ack = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_valid"}, 32'(bus.result_valid), 1);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_timed_out"}, 32'(bus.timed_out), 32'(eto));
    chk({tag, "_min"}, bus.min_out, em);
    chk({tag, "_v0"}, bus.v0_out, ev0);
    chk({tag, "_v1"}, bus.v1_out, ev1);
    chk({tag, "_best"}, 32'(bus.best_core), 32'(eb));
    chk({tag, "_mask"}, 32'(bus.captured_mask), 32'(emask));
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_min"}, bus.min_out, 32'hffffffff);
    chk({tag, "_v0"}, bus.v0_out, 0);
    chk({tag, "_v1"}, bus.v1_out, 0);
    chk({tag, "_best"}, 32'(bus.best_core), 0);
    chk({tag, "_mask"}, 32'(bus.captured_mask), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_valid"}, 32'(bus.result_valid), 0);
    chk({tag, "_to"}, 32'(bus.timed_out), 0);
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b1;
    bus.ack = 1'b0;
    bus.core_done = '1;
    bus.min_in = '0;
    bus.v0_in = '0;
    bus.v1_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    reset = 1'b0;
    bus.start = 1'b0;
    mn = '{50, 40, 30, 20, 25, 35, 45, 55};
    for (int i = 0; i < 8; i++) begin r[i] = 0; a[i] = i; b[i] = 10 + i; end
    run_frame("basic", 1'b0);
    chk("basic_min20", bus.min_out, 20);
    chk("basic_best3", 32'(bus.best_core), 3);
    chk("basic_v0", bus.v0_out, 3);
    chk("basic_v1", bus.v1_out, 13);
    for (int k = 0; k < 10; k++) begin
      bus.core_done = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.result_valid), 1);
      chk("hold_min", bus.min_out, em);
      chk("hold_best", 32'(bus.best_core), 32'(eb));
      chk("hold_mask", 32'(bus.captured_mask), 32'(emask));
    end
    bus.ack = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    chk("ack_valid", 32'(bus.result_valid), 0);
    chk("ack_busy", 32'(bus.busy), 0);
    chk("ack_min", bus.min_out, em);
    chk("ack_v1", bus.v1_out, ev1);
    chk("ack_mask", 32'(bus.captured_mask), 32'(emask));
    bus.core_done = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ignore_mask", 32'(bus.captured_mask), 32'(emask));
    chk("idle_ignore_busy", 32'(bus.busy), 0);
    for (int i = 0; i < 8; i++) begin mn[i] = 100; r[i] = 8; a[i] = $urandom; b[i] = $urandom; end
    mn[6] = 7; mn[2] = 7; r[6] = 0; r[2] = 5;
    run_frame("tie", 1'b0);
    chk("tie_best2", 32'(bus.best_core), 2);
    chk("tie_min7", bus.min_out, 7);
    for (int i = 0; i < 8; i++) begin r[i] = 99; mn[i] = 1; end
    r[0] = 0; r[1] = 0; mn[0] = 9; mn[1] = 4;
    run_frame("timeout", 1'b0);
    chk("timeout_flag", 32'(bus.timed_out), 1);
    chk("timeout_mask", 32'(bus.captured_mask), 3);
    chk("timeout_min4", bus.min_out, 4);
    for (int i = 0; i < 8; i++) r[i] = 99;
    run_frame("timeout_empty", 1'b0);
    for (int i = 0; i < 8; i++) r[i] = 0;
    r[7] = 15;
    run_frame("last_edge", 1'b0);
    for (int i = 0; i < 8; i++) begin r[i] = 0; mn[i] = $urandom_range(0, 1000); end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.core_done = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_mask", 32'(bus.captured_mask), 7);
    reset = 1'b1;
    bus.start = 1'b1;
    bus.ack = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.ack = 1'b0;
    chk_reset_state("midreset");
    run_frame("after_reset", 1'b0);
    for (int f = 0; f < 14; f++) begin
      for (int i = 0; i < 8; i++) begin
        r[i] = $urandom_range(0, 20);
        mn[i] = $urandom_range(0, 15);
        a[i] = $urandom;
        b[i] = $urandom;
      end
      run_frame($sformatf("rand%0d", f), 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sad_result_collector.md
SAD_RESULT_COLLECTOR -- requirements
Module: sad_result_collector

Interface
REQ-001 Parameter NUM_CORES, default 8: number of datapath cores reporting results.
REQ-002 Parameter DATA_WIDTH, default 32: width of each MIN, v0 and v1 value.
REQ-003 Parameter TIMEOUT, default 65535: maximum COLLECT-state cycles before a forced finish.
REQ-004 Clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  begins a new collection frame.
REQ-007 Core_Done  input  NUM_CORES  level per core; bit i high means core i's result inputs are valid and stable.
REQ-008 MIN_IN  input  NUM_CORES*DATA_WIDTH  per-core SAD minimum; core i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 v0_IN  input  NUM_CORES*DATA_WIDTH  per-core v0 coordinate, same packing.
REQ-010 v1_IN  input  NUM_CORES*DATA_WIDTH  per-core v1 coordinate, same packing.
REQ-011 Ack  input  1  consumer accepts the final result.
REQ-012 MIN_OUT  output  DATA_WIDTH  best (smallest) SAD captured so far.
REQ-013 v0_OUT  output  DATA_WIDTH  v0 of the best result.
REQ-014 v1_OUT  output  DATA_WIDTH  v1 of the best result.
REQ-015 Best_Core  output  clog2(NUM_CORES)  index of the core that supplied the best result.
REQ-016 Captured_Mask  output  NUM_CORES  bit i set once core i's result has been captured.
REQ-017 Busy  output  1  high while in COLLECT.
REQ-018 Result_Valid  output  1  high while in DONE.
REQ-019 Timed_Out  output  1  high in DONE when the finish was forced by timeout.

Function
REQ-020 States: IDLE, COLLECT, DONE; all outputs are registered.
REQ-021 IDLE with Start=1 -> COLLECT: clear Captured_Mask, set MIN_OUT to all ones, clear v0_OUT, v1_OUT and Best_Core, zero the cycle counter, clear Timed_Out.
REQ-022 COLLECT, each cycle: pending = Core_Done & ~Captured_Mask; if pending != 0, capture the lowest-index pending core i (one core per cycle max) and set Captured_Mask[i].
REQ-023 Capture compare: replace best when MIN_IN[i] < MIN_OUT (unsigned), or MIN_IN[i] == MIN_OUT and i < Best_Core; otherwise best is unchanged.
REQ-024 Replacement loads MIN_OUT, v0_OUT and v1_OUT from core i and sets Best_Core = i, all on the same edge.
REQ-025 The edge capturing the last uncaptured core moves to DONE with Result_Valid=1 and the final best already on the outputs.
REQ-026 All Core_Done high on COLLECT entry: Result_Valid rises exactly NUM_CORES cycles after the Start edge.
REQ-027 The cycle counter increments each COLLECT cycle; counter == TIMEOUT-1 with mask incomplete after this cycle's capture -> DONE with Timed_Out=1.
REQ-028 Completion and timeout on the same edge: the final capture is included and Timed_Out=0.
REQ-029 Timeout with zero captures: MIN_OUT=all ones, Best_Core=0, Captured_Mask=0.
REQ-030 Start during COLLECT is ignored.
REQ-031 A Core_Done bit that falls after capture has no effect; a bit that falls before capture leaves that core pending-free.
REQ-032 DONE with Ack=1 -> IDLE; Result_Valid and Timed_Out clear, while MIN_OUT, v0_OUT, v1_OUT, Best_Core and Captured_Mask hold.
REQ-033 DONE with Start=1 (Ack either value) -> COLLECT, reinitialised per REQ-021.
REQ-034 Core_Done bits are ignored in IDLE and DONE.

Reset
REQ-035 Reset=1 at a rising edge forces IDLE from any state, including mid-COLLECT, discarding partial results.
REQ-036 Reset values: MIN_OUT=all ones, v0_OUT=0, v1_OUT=0, Best_Core=0, Captured_Mask=0, Busy=0, Result_Valid=0, Timed_Out=0, counter=0.
REQ-037 Reset takes priority over Start and Ack.

Verification
REQ-038 All done, MIN = {50,40,30,20,25,35,45,55}, v0[i]=i, v1[i]=10+i, Start -> after 8 cycles Result_Valid=1, MIN_OUT=20, Best_Core=3, v0_OUT=3, v1_OUT=13.
REQ-039 Tie: cores 6 and 2 both MIN=7, core 6 done 5 cycles before core 2, rest MIN=100 -> Best_Core=2, MIN_OUT=7.
REQ-040 TIMEOUT=16, only cores 0 and 1 done with MIN 9 and 4 -> DONE at cycle 16, Timed_Out=1, Captured_Mask=8'b00000011, MIN_OUT=4.
REQ-041 Reset pulsed after 3 captures -> next cycle IDLE with all REQ-036 values; a new Start produces a correct full result.
REQ-042 Result_Valid high, Ack=0 held 10 cycles -> outputs stable; Ack=1 -> IDLE with values held; Start in DONE -> Busy=1 next cycle, MIN_OUT=all ones.
